// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup and execute-resolve signals shared between the pipeline and
// the branch predictor.
interface branch_predict_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic [XLEN-1:0]  if_pc;
  logic             if_predict_taken;
  logic             ex_valid;
  logic             ex_branch;
  logic [2:0]       ex_func3;
  logic [XLEN-1:0]  ex_a;
  logic [XLEN-1:0]  ex_b;
  logic [XLEN-1:0]  ex_pc;
  logic             ex_pred_taken;
  logic             ex_taken;
  logic             ex_mispredict;
  logic             ex_illegal;
  logic [CNT_W-1:0] branch_count;
  logic [CNT_W-1:0] mispredict_count;

  modport master (
    output if_pc, ex_valid, ex_branch, ex_func3, ex_a, ex_b, ex_pc, ex_pred_taken,
    input  if_predict_taken, ex_taken, ex_mispredict, ex_illegal,
           branch_count, mispredict_count
  );

  modport slave (
    input  if_pc, ex_valid, ex_branch, ex_func3, ex_a, ex_b, ex_pc, ex_pred_taken,
    output if_predict_taken, ex_taken, ex_mispredict, ex_illegal,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by
// PC, a branch-condition resolver, and saturating accuracy statistics.
module branch_predict_unit #(
  parameter int         XLEN       = 32,
  parameter int         BHT_DEPTH  = 64,
  parameter int         CNT_W      = 16,
  parameter logic [1:0] INIT_STATE = 2'b01
) (
  input  logic clk,
  input  logic reset,
  branch_predict_unit_if.slave bus
);
  localparam int IDX = $clog2(BHT_DEPTH);

  logic [1:0]       bht [BHT_DEPTH];
  logic [IDX-1:0]   if_idx;
  logic [IDX-1:0]   ex_idx;
  logic [1:0]       ex_cur;
  logic [1:0]       ex_next;
  logic             resolve;
  logic             func_legal;
  logic             cond_true;
  logic             legal_resolve;
  logic             taken;
  logic             mispredict;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispredict_cnt;
  logic             unused_pc_bits;

  assign if_idx = bus.if_pc[IDX+1:2];
  assign ex_idx = bus.ex_pc[IDX+1:2];
  assign ex_cur = bht[ex_idx];

  // Tag bits and the byte offset do not take part in indexing; aliasing is intended.
  assign unused_pc_bits = ^{bus.if_pc[XLEN-1:IDX+2], bus.if_pc[1:0],
                            bus.ex_pc[XLEN-1:IDX+2], bus.ex_pc[1:0]};

  // Reset gates the lookup so the prediction reflects INIT_STATE while held.
  assign bus.if_predict_taken = reset ? bht[if_idx][1] : INIT_STATE[1];

  assign resolve = bus.ex_valid & bus.ex_branch & reset;

  always_comb begin
    func_legal = 1'b1;
    cond_true  = 1'b0;
    case (bus.ex_func3)
      3'b000:  cond_true = (bus.ex_a == bus.ex_b);
      3'b001:  cond_true = (bus.ex_a != bus.ex_b);
      3'b100:  cond_true = ($signed(bus.ex_a) <  $signed(bus.ex_b));
      3'b101:  cond_true = ($signed(bus.ex_a) >= $signed(bus.ex_b));
      3'b110:  cond_true = (bus.ex_a <  bus.ex_b);
      3'b111:  cond_true = (bus.ex_a >= bus.ex_b);
      default: func_legal = 1'b0;
    endcase
  end

  assign legal_resolve     = resolve & func_legal;
  assign taken             = legal_resolve & cond_true;
  assign mispredict        = legal_resolve & (cond_true ^ bus.ex_pred_taken);
  assign bus.ex_taken      = taken;
  assign bus.ex_mispredict = mispredict;
  assign bus.ex_illegal    = resolve & ~func_legal;

  always_comb begin
    ex_next = ex_cur;
    if (cond_true) begin
      if (ex_cur != 2'b11) ex_next = ex_cur + 2'd1;
    end else begin
      if (ex_cur != 2'b00) ex_next = ex_cur - 2'd1;
    end
  end

  // The lookup port reads the stored value, so a same-cycle update is only
  // visible from the following cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= INIT_STATE;
    end else if (legal_resolve) begin
      bht[ex_idx] <= ex_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (legal_resolve) begin
      if (branch_cnt != '1) branch_cnt <= branch_cnt + 1'b1;
      if (mispredict && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + 1'b1;
    end
  end

  assign bus.branch_count     = branch_cnt;
  assign bus.mispredict_count = mispredict_cnt;
endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
 XLEN, 32, operand and PC width.
 BHT_DEPTH, 64, number of 2-bit counters; power of two, 4 to 1024.
 CNT_W, 16, width of each statistics counter.
 INIT_STATE, 2'b01, counter value loaded at reset.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
 clk  in  1  single clock; all state updates on rising edge.
 reset  in  1  asynchronous, active-low reset.
 if_pc  in  XLEN  fetch-stage PC for lookup.
 if_predict_taken  out  1  prediction for if_pc.
 ex_valid  in  1  EX-stage instruction valid.
 ex_branch  in  1  EX instruction is a conditional branch.
 ex_func3  in  3  branch condition code.
 ex_a, ex_b  in  XLEN  rs1/rs2 operand values.
 ex_pc  in  XLEN  PC of the EX instruction.
 ex_pred_taken  in  1  prediction carried down the pipeline with this instruction.
 ex_taken  out  1  resolved branch outcome.
 ex_mispredict  out  1  resolved outcome differs from ex_pred_taken.
 ex_illegal  out  1  reserved func3 on a valid branch.
 branch_count  out  CNT_W  resolved legal branches.
 mispredict_count  out  CNT_W  mispredicted legal branches.

Function
REQ-003 Index SHALL be pc[IDX+1:2], where IDX = log2(BHT_DEPTH); the same rule applies to if_pc and ex_pc.
REQ-004 if_predict_taken SHALL be combinational and equal bit 1 of the counter at the if_pc index.
REQ-005 "Resolve" SHALL mean ex_valid=1 and ex_branch=1 and reset=1.
REQ-006 On resolve, ex_taken SHALL be combinational:
 000: a==b.
 001: a!=b.
 100: signed a<b.
 101: signed a>=b.
 110: unsigned a<b.
 111: unsigned a>=b.
REQ-007 func3 010/011 on resolve SHALL give ex_illegal=1, ex_taken=0, ex_mispredict=0, no table update, no counter increment.
REQ-008 When not resolving, ex_taken, ex_mispredict and ex_illegal SHALL be 0.
REQ-009 On a legal resolve, ex_mispredict SHALL equal ex_taken XOR ex_pred_taken, combinationally in the same cycle.
REQ-010 On a legal resolve, the counter at the ex_pc index SHALL update at the next rising edge:
 taken: +1, saturating at 2'b11.
 not taken: -1, saturating at 2'b00.
REQ-011 Counter states SHALL be 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; prediction is taken for 10 and 11.
REQ-012 Same-cycle lookup and update of the same index SHALL return the pre-update value (no bypass); the new value is visible the following cycle.
REQ-013 branch_count SHALL increment by 1 per legal resolve, saturating at all-ones.
REQ-014 mispredict_count SHALL increment by 1 per legal mispredicted resolve, saturating at all-ones.
REQ-015 Only one resolve per cycle SHALL be supported; aliased PCs share a counter by design.

Reset
REQ-016 reset=0 SHALL asynchronously set every BHT counter to INIT_STATE, both statistics counters to 0, and all ex_* outputs to 0.
REQ-017 if_predict_taken SHALL read INIT_STATE[1] while reset=0.
REQ-018 Reset asserted mid-update SHALL win: no counter write on that edge.
REQ-019 The first update SHALL occur on the first rising edge with reset=1 and a resolve.

Verification
REQ-020 Reset release, if_pc=0x100 -> if_predict_taken=0; branch_count=0; mispredict_count=0.
REQ-021 Resolve pc=0x100, func3=000, a=b=5, pred=0 -> ex_taken=1, ex_mispredict=1 same cycle; next cycle if_pc=0x100 predicts 1 (counter 10), both statistics counters=1.
REQ-022 Resolve four taken at pc=0x40 -> counter saturates at 11; then one not-taken -> 10, still predicts taken.
REQ-023 func3=100, a=0xFFFFFFFF, b=1 -> taken; func3=110, same operands -> not taken.
REQ-024 func3=011 on resolve -> ex_illegal=1; counters and table unchanged.
REQ-025 Same-cycle if_pc=ex_pc=0x80 resolve taken from 01 -> if_predict_taken=0 this cycle, 1 next cycle; reset pulse mid-sequence -> all state returns to reset values immediately.
